// File: rtl/sprite_slot_writer.sv
// sprite_slot_writer: bus initiator for the sprite video slot.
// Copies a PIX_W-bit-per-pixel bitmap from an external ROM into the slot's
// sprite RAM. Pushes the bypass/x0/y0/ctrl register shadow to the slot only
// on frame boundaries, so the sprite never tears mid-frame.
//
// Optional feature macro: SPRITE_DIRTY_SKIP_EN
//   defined   : a register pass writes only fields that changed since the last pass
//   undefined : every register pass writes all four fields
//
// state | meaning
// IDLE  | waiting for load_start or frame_tick with an update pending
// LOAD  | streaming ROM pixels into sprite RAM, one write per cycle
// DRAIN | last RAM write on the bus; load_done follows
// REG   | writing the snapshotted register fields to the slot
module sprite_slot_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int PIX_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [PIX_W-1:0]      rom_data,
  input  logic                  upd_req,
  input  logic [10:0]           x_in,
  input  logic [10:0]           y_in,
  input  logic [4:0]            ctrl_in,
  input  logic                  bypass_in,
  input  logic                  frame_tick,
  output logic                  cs,
  output logic                  write,
  output logic [13:0]           addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  load_done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << ADDR_WIDTH) - 1);

  localparam logic [10:0] X_RST      = 11'd0;
  localparam logic [10:0] Y_RST      = 11'd0;
  localparam logic [4:0]  CTRL_RST   = 5'b00100;
  localparam logic        BYPASS_RST = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_REG
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  cs_q, cs_d;
  logic [13:0]           addr_q, addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
  logic                  pending_q, pending_d;

  // Shadow captured on upd_req
  logic [10:0] sh_x_q, sh_x_d;
  logic [10:0] sh_y_q, sh_y_d;
  logic [4:0]  sh_ctrl_q, sh_ctrl_d;
  logic        sh_bypass_q, sh_bypass_d;

  // Snapshot of the shadow taken when a register pass starts
  logic [10:0] wc_x_q, wc_x_d;
  logic [10:0] wc_y_q, wc_y_d;
  logic [4:0]  wc_ctrl_q, wc_ctrl_d;
  logic        wc_bypass_q, wc_bypass_d;

  // Fields still to be written in the current register pass (bit k = field k)
  logic [3:0]  mask_q, mask_d;

  logic [3:0]  start_mask;
  logic [1:0]  fld;
  logic [3:0]  rem_mask;
  logic [CW-1:0] cnt_plus2;

`ifdef SPRITE_DIRTY_SKIP_EN
  logic [10:0] last_x_q, last_x_d;
  logic [10:0] last_y_q, last_y_d;
  logic [4:0]  last_ctrl_q, last_ctrl_d;
  logic        last_bypass_q, last_bypass_d;
`endif

  // Field index 0..3 = bypass, x0, y0, ctrl; register space lives at addr[13]=1
  function automatic logic [13:0] reg_addr(input logic [1:0] f);
    return 14'h2000 | 14'(f);
  endfunction

  function automatic logic [31:0] reg_data(
    input logic [1:0]  f,
    input logic        b,
    input logic [10:0] x,
    input logic [10:0] y,
    input logic [4:0]  c
  );
    logic [31:0] d;
    case (f)
      2'd0:    d = 32'(b);
      2'd1:    d = 32'(x);
      2'd2:    d = 32'(y);
      default: d = 32'(c);
    endcase
    return d;
  endfunction

  function automatic logic [1:0] first_field(input logic [3:0] m);
    logic [1:0] f;
    if (m[0])      f = 2'd0;
    else if (m[1]) f = 2'd1;
    else if (m[2]) f = 2'd2;
    else           f = 2'd3;
    return f;
  endfunction

  // Which fields a register pass starting now has to write
`ifdef SPRITE_DIRTY_SKIP_EN
  assign start_mask = {sh_ctrl_q   != last_ctrl_q,
                       sh_y_q      != last_y_q,
                       sh_x_q      != last_x_q,
                       sh_bypass_q != last_bypass_q};
`else
  assign start_mask = 4'hF;
`endif

  // Next-state and next-output computation for the whole controller
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    cs_d        = 1'b0;
    addr_d      = '0;
    wr_data_d   = '0;
    load_done_d = 1'b0;
    pending_d   = pending_q;
    sh_x_d      = sh_x_q;
    sh_y_d      = sh_y_q;
    sh_ctrl_d   = sh_ctrl_q;
    sh_bypass_d = sh_bypass_q;
    wc_x_d      = wc_x_q;
    wc_y_d      = wc_y_q;
    wc_ctrl_d   = wc_ctrl_q;
    wc_bypass_d = wc_bypass_q;
    mask_d      = mask_q;
    fld         = 2'd0;
    rem_mask    = 4'h0;
    cnt_plus2   = cnt_q + CW'(2);
`ifdef SPRITE_DIRTY_SKIP_EN
    last_x_d      = last_x_q;
    last_y_d      = last_y_q;
    last_ctrl_d   = last_ctrl_q;
    last_bypass_d = last_bypass_q;
`endif

    case (state_q)
      S_IDLE: begin
        rom_addr_d = '0;
        if (frame_tick && pending_q) begin
          // Tick wins over a same-cycle load_start; that load is dropped
          wc_x_d      = sh_x_q;
          wc_y_d      = sh_y_q;
          wc_ctrl_d   = sh_ctrl_q;
          wc_bypass_d = sh_bypass_q;
          pending_d   = 1'b0;
`ifdef SPRITE_DIRTY_SKIP_EN
          last_x_d      = sh_x_q;
          last_y_d      = sh_y_q;
          last_ctrl_d   = sh_ctrl_q;
          last_bypass_d = sh_bypass_q;
`endif
          fld      = first_field(start_mask);
          rem_mask = start_mask & ~(4'b0001 << fld);
          if (start_mask != 4'h0) begin
            cs_d      = 1'b1;
            addr_d    = reg_addr(fld);
            wr_data_d = reg_data(fld, sh_bypass_q, sh_x_q, sh_y_q, sh_ctrl_q);
          end
          mask_d  = rem_mask;
          state_d = S_REG;
        end else if (load_start) begin
          // rom_addr already held 0 this cycle, so pixel 0 arrives next cycle
          cnt_d      = '0;
          rom_addr_d = ADDR_WIDTH'(1);
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        // rom_data belongs to pixel cnt_q; rom_addr runs one pixel ahead
        cs_d      = 1'b1;
        addr_d    = 14'(cnt_q[ADDR_WIDTH-1:0]);
        wr_data_d = 32'(rom_data);
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) begin
          rom_addr_d = '0;
          state_d    = S_DRAIN;
        end else if (cnt_plus2 <= LAST_IDX) begin
          rom_addr_d = cnt_plus2[ADDR_WIDTH-1:0];
        end else begin
          rom_addr_d = '0;
        end
      end

      S_DRAIN: begin
        load_done_d = 1'b1;
        state_d     = S_IDLE;
      end

      S_REG: begin
        if (mask_q != 4'h0) begin
          fld       = first_field(mask_q);
          cs_d      = 1'b1;
          addr_d    = reg_addr(fld);
          wr_data_d = reg_data(fld, wc_bypass_q, wc_x_q, wc_y_q, wc_ctrl_q);
          mask_d    = mask_q & ~(4'b0001 << fld);
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A new update always lands in the shadow and re-arms pending, even when
    // it coincides with the tick that consumes the previous one
    if (upd_req) begin
      sh_x_d      = x_in;
      sh_y_d      = y_in;
      sh_ctrl_d   = ctrl_in;
      sh_bypass_d = bypass_in;
      pending_d   = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Controller state and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      pending_q   <= 1'b0;
      sh_x_q      <= X_RST;
      sh_y_q      <= Y_RST;
      sh_ctrl_q   <= CTRL_RST;
      sh_bypass_q <= BYPASS_RST;
      wc_x_q      <= X_RST;
      wc_y_q      <= Y_RST;
      wc_ctrl_q   <= CTRL_RST;
      wc_bypass_q <= BYPASS_RST;
      mask_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      pending_q   <= pending_d;
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_ctrl_q   <= sh_ctrl_d;
      sh_bypass_q <= sh_bypass_d;
      wc_x_q      <= wc_x_d;
      wc_y_q      <= wc_y_d;
      wc_ctrl_q   <= wc_ctrl_d;
      wc_bypass_q <= wc_bypass_d;
      mask_q      <= mask_d;
    end
  end

`ifdef SPRITE_DIRTY_SKIP_EN
  // Last values written to the slot, compared against the shadow on each tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_x_q      <= X_RST;
      last_y_q      <= Y_RST;
      last_ctrl_q   <= CTRL_RST;
      last_bypass_q <= BYPASS_RST;
    end else begin
      last_x_q      <= last_x_d;
      last_y_q      <= last_y_d;
      last_ctrl_q   <= last_ctrl_d;
      last_bypass_q <= last_bypass_d;
    end
  end
`endif

  assign rom_addr  = rom_addr_q;
  assign cs        = cs_q;
  assign write     = cs_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_sprite_slot_writer.sv
// Bench for sprite_slot_writer (ADDR_WIDTH=4): stimulus pushes expected slot
// writes (cycle, addr, data) into a queue; a negedge monitor pops and checks
// every write the DUT puts on the bus.
module tb_sprite_slot_writer;

  localparam int AW = 4;
  localparam int NP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [1:0]    rom_data = 2'd0;
  logic          upd_req = 1'b0;
  logic [10:0]   x_in = '0;
  logic [10:0]   y_in = '0;
  logic [4:0]    ctrl_in = '0;
  logic          bypass_in = 1'b0;
  logic          frame_tick = 1'b0;
  logic          cs;
  logic          write;
  logic [13:0]   addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          load_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [13:0] a;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  sprite_slot_writer #(.ADDR_WIDTH(AW), .PIX_W(2)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .upd_req(upd_req), .x_in(x_in), .y_in(y_in), .ctrl_in(ctrl_in),
    .bypass_in(bypass_in), .frame_tick(frame_tick),
    .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM content is i%4, one-cycle read latency
  always @(posedge clk) rom_data <= rom_addr[1:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_wr(input int c, input logic [13:0] a, input logic [31:0] d);
    exp_t e;
    e.c = c; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic exp_regs(input int t, input logic b, input int x, input int y, input int c);
    exp_wr(t + 1, 14'h2000, 32'(b));
    exp_wr(t + 2, 14'h2001, 32'(x));
    exp_wr(t + 3, 14'h2002, 32'(y));
    exp_wr(t + 4, 14'h2003, 32'(c));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_upd(input int x, input int y, input int c, input logic b);
    x_in = 11'(x); y_in = 11'(y); ctrl_in = 5'(c); bypass_in = b;
    upd_req = 1'b1;
    step();
    upd_req = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cs"}, 32'(cs), 0);
    chk({tag, "_write"}, 32'(write), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
  endtask

  // Full load: 16 writes at t+2..t+17, load_done only at t+18
  task automatic full_load(input string tag);
    int t;
    t = cyc;
    for (int i = 0; i < NP; i++) exp_wr(t + 2 + i, 14'(i), 32'(i % 4));
    pulse_load();
    chk({tag, "_busy_t1"}, 32'(busy), 1);
    for (int k = 2; k <= NP + 2; k++) begin
      step();
      chk({tag, "_busy"}, 32'(busy), 32'(k <= NP + 1));
      chk({tag, "_load_done"}, 32'(load_done), 32'(k == NP + 2));
    end
  endtask

  // Monitor: every bus write must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && cs) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", 32'(addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(e.c));
        chk("wr_addr", 32'(addr), 32'(e.a));
        chk("wr_data", wr_data, e.d);
        chk("write_eq_cs", 32'(write), 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout cycle=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    idle(3);
    chk_reset_outs("por");
    reset = 1'b0;
    idle(5);

    // Bitmap copy
    full_load("load1");
    idle(3);

    // Register update: no writes until the tick
    do_upd(100, 200, 2, 1'b1);
    idle(4);
    t = cyc;
    exp_regs(t, 1'b1, 100, 200, 2);
    pulse_tick();
    idle(4);
    chk("reg1_busy_t5", 32'(busy), 0);
    chk("reg1_cs_t5", 32'(cs), 0);
    // Second tick with nothing pending
    pulse_tick();
    idle(5);

    // Only y changes
    do_upd(100, 201, 2, 1'b1);
    t = cyc;
`ifdef SPRITE_DIRTY_SKIP_EN
    exp_wr(t + 1, 14'h2002, 32'd201);
`else
    exp_regs(t, 1'b1, 100, 201, 2);
`endif
    pulse_tick();
    idle(5);
    chk("dirty1_busy", 32'(busy), 0);
    // Identical update
    do_upd(100, 201, 2, 1'b1);
    t = cyc;
`ifndef SPRITE_DIRTY_SKIP_EN
    exp_regs(t, 1'b1, 100, 201, 2);
`endif
    pulse_tick();
    idle(5);
    chk("dirty2_busy", 32'(busy), 0);

    // Collision: tick with pending beats load_start
    do_upd(50, 60, 7, 1'b0);
    t = cyc;
    exp_regs(t, 1'b0, 50, 60, 7);
    frame_tick = 1'b1;
    load_start = 1'b1;
    step();
    frame_tick = 1'b0;
    load_start = 1'b0;
    idle(5);
    chk("coll_busy", 32'(busy), 0);
    chk("coll_load_done", 32'(load_done), 0);
    idle(20);

    // Tick during LOAD is ignored; registers go out on the next tick
    do_upd(300, 400, 9, 1'b1);
    t = cyc;
    for (int i = 0; i < NP; i++) exp_wr(t + 2 + i, 14'(i), 32'(i % 4));
    pulse_load();
    idle(4);
    pulse_tick();
    idle(12);
    chk("ld_tick_load_done", 32'(load_done), 1);
    step();
    chk("ld_tick_busy", 32'(busy), 0);
    t = cyc;
    exp_regs(t, 1'b1, 300, 400, 9);
    pulse_tick();
    // Update during REG does not disturb in-flight writes
    do_upd(5, 400, 9, 1'b1);
    idle(6);
    t = cyc;
`ifdef SPRITE_DIRTY_SKIP_EN
    exp_wr(t + 1, 14'h2001, 32'd5);
`else
    exp_regs(t, 1'b1, 5, 400, 9);
`endif
    pulse_tick();
    idle(6);

    // Abort a load at write #7 with reset
    t = cyc;
    for (int i = 0; i < 6; i++) exp_wr(t + 2 + i, 14'(i), 32'(i % 4));
    pulse_load();
    idle(7);
    reset = 1'b1;
    #1;
    chk_reset_outs("abort");
    idle(2);
    reset = 1'b0;
    idle(6);
    chk("abort_idle_busy", 32'(busy), 0);
    full_load("load2");
    idle(5);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_slot_writer.md
Name: sprite_slot_writer

Overview:
- Bus initiator for the sprite video slot. Drives its write-only slot bus: `cs`, `write`, `addr[13:0]`, `wr_data[31:0]`.
- Bulk-copies a 2-bit-per-pixel sprite bitmap from an external ROM into the slot's sprite RAM.
- Pushes position/control/bypass register updates only on frame boundaries, so the sprite never tears mid-frame.
- Sits between the game-logic FSM and the sprite slot.

Parameters:
- ADDR_WIDTH, 10, sprite RAM address width; bitmap size N = 2^ADDR_WIDTH pixels.
- PIX_W, 2, bits per pixel from ROM; placed in `wr_data[PIX_W-1:0]`.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load_start  in  1  1-cycle pulse: start bitmap copy
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  PIX_W  ROM data, valid exactly 1 cycle after rom_addr
- upd_req  in  1  1-cycle pulse: capture x_in/y_in/ctrl_in/bypass_in into shadow, set pending
- x_in  in  11  new sprite x0
- y_in  in  11  new sprite y0
- ctrl_in  in  5  new control (animation/colour)
- bypass_in  in  1  new bypass flag
- frame_tick  in  1  1-cycle pulse at start of vertical blank
- cs  out  1  slot select
- write  out  1  slot write strobe (always equal to cs)
- addr  out  14  slot address
- wr_data  out  32  slot write data
- busy  out  1  high while not IDLE
- load_done  out  1  1-cycle pulse after last bitmap write

Behaviour:
- All bus outputs are registered.
- Reset values: cs=0, write=0, addr=0, wr_data=0, rom_addr=0, busy=0, load_done=0, pending=0.
- Shadow reset values: x=0, y=0, ctrl=5'b00100, bypass=0.
- Address map:
  - RAM: `addr[13]=0`, `addr[ADDR_WIDTH-1:0]` = pixel index; other bits 0.
  - Registers: `addr[13]=1`, `addr[12:2]=0`, `addr[1:0]`: 00 bypass, 01 x0, 10 y0, 11 ctrl.
- wr_data is zero-extended in all cases.
- FSM states: IDLE, LOAD, DRAIN, REG.
- IDLE:
  - If `frame_tick` && pending: go to REG. This has priority over `load_start` in the same cycle; that `load_start` is dropped.
  - Else if `load_start`: go to LOAD, cnt=0.
- LOAD:
  - rom_addr=cnt each cycle; cnt increments.
  - One cycle later, register a write: cs=write=1, addr=cnt_d, wr_data=rom_data.
  - After cnt=N-1 is issued, go to DRAIN.
- DRAIN:
  - Final write (addr N-1) is on the bus.
  - Next cycle: cs=0, load_done=1, return to IDLE.
- Load latency: `load_start` accepted at cycle t gives writes on cycles t+2 .. t+N+1. load_done is high at t+N+2. Exactly N contiguous writes, no gaps.
- REG:
  - At entry, snapshot the shadow into a write copy and clear pending.
  - 4 consecutive write cycles in order bypass, x0, y0, ctrl.
  - frame_tick at cycle t gives writes at t+1 .. t+4; cs=0 at t+5; return to IDLE.
- `upd_req` is accepted in any state. It overwrites the shadow and sets pending. During REG it does not alter the in-flight writes and is applied at the next `frame_tick`.
- `frame_tick` is ignored outside IDLE; pending is retained.
- `frame_tick` with pending=0 produces no bus activity.
- `load_start` is ignored while busy (not queued).
- cs is 0 on every cycle without a write. The bus never carries a read.
- Reset mid-operation: all outputs return to reset values immediately (async). The partial RAM copy is not resumed.
- cnt is ADDR_WIDTH+1 bits wide, so N-1 terminates without wrapping.

Optional Feature:
- Macro: `SPRITE_DIRTY_SKIP_EN`.
- Defined:
  - Keep last-written copies of bypass/x0/y0/ctrl (reset to the shadow reset values).
  - REG writes only fields that differ, in the same order, back-to-back with no idle gaps.
  - If none differ, REG issues zero writes and returns to IDLE next cycle with pending cleared.
- Undefined: all 4 register writes on every REG pass.

Test Plan:
- Reset: assert reset mid-run -> same cycle cs=0, write=0, addr=0, wr_data=0, busy=0. After release, no bus activity until a stimulus.
- Load (ADDR_WIDTH=4): ROM holds i%4, `load_start` at t -> 16 writes at t+2..t+17, addr 0..15 with addr[13]=0, wr_data=i%4. load_done=1 only at t+18; busy low at t+18.
- Register update:
  - `upd_req` with x=100, y=200, ctrl=5'b00010, bypass=1 -> no writes.
  - Then `frame_tick` -> addr 0x2000/0x2001/0x2002/0x2003 with data 1/100/200/2 on 4 consecutive cycles.
  - A second `frame_tick` with no new `upd_req` -> no writes.
- Collision: `frame_tick` (pending=1) and `load_start` in the same IDLE cycle -> REG runs, load is dropped, no RAM writes. A `frame_tick` during LOAD -> no register writes; they occur on the next tick after load_done.
- Abort: reset at write #7 of a load -> bus idle immediately. A new `load_start` restarts from addr 0.
- `SPRITE_DIRTY_SKIP_EN`: after the update above, `upd_req` changing only y to 201 and `frame_tick` -> single write addr 0x2002, data 201. An identical `upd_req` plus tick -> zero writes.
